// File: rtl/mmix_defs.sv
// Shared MMIX definitions: fetch record, interrupt bit positions,
// the SWYM no-op encoding and the fetch_queue state type.
package mmix_defs;

   localparam int PX_BIT = 39;
   localparam int F_BIT  = 46;

   localparam logic [31:0] SWYM = 32'hFD00_0000;

   typedef struct packed {
      logic [63:0] loc;
      logic [31:0] inst;
      logic [63:0] interrupt;
   } fetch;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DISCARD,
      STALL
   } fq_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch records.
// Ports: clk, reset_n, push/pop/flush, din, dout (head),
//        count, empty, full. Pointers wrap mod DEPTH.
module fetch_fifo
   import mmix_defs::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  fetch        din,
   output fetch        dout,
   output logic [AW:0] count,
   output logic        empty,
   output logic        full
);

   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW:0] ONE = CW'(1);

   fetch mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign do_pop = pop && !empty;
   assign dout   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !do_pop)
            count <= count + ONE;
         else if (!push && do_pop)
            count <= count - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch pointer, sequences fetch_unit one
// instruction at a time and buffers records for dispatch.
// Ports: clk, reset_n; fetch_enable/fetch_ptr/fetch_done/fetch_head
// to fetch_unit; redirect/redirect_addr restart; out_valid/out_head/
// out_ready to dispatch; stalled after a faulting record.
// FETCH_QUEUE_BYPASS_EN: empty-FIFO records go straight to out_head.
module fetch_queue
   import mmix_defs::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h8000_0000_0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        fetch_enable,
   output logic [63:0] fetch_ptr,
   input  logic        fetch_done,
   input  fetch        fetch_head,
   input  logic        redirect,
   input  logic [63:0] redirect_addr,
   output logic        out_valid,
   output fetch        out_head,
   input  logic        out_ready,
   output logic        stalled
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW:0] ONE = CW'(1);

   fq_state_t   state;
   fq_state_t   state_next;
   logic [AW:0] count;
   logic [AW:0] count_next;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        room;
   logic        fault;
   logic        done_ok;
   logic        enable_next;
   fetch        fifo_head;
   logic        unused;

   assign unused  = ^redirect_addr[1:0];
   assign done_ok = (state == WAIT) && fetch_done && !redirect;
   assign fault   = fetch_head.interrupt[PX_BIT]
                  | fetch_head.interrupt[F_BIT];
   assign pop     = out_ready && !empty;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = done_ok && empty;
   // a bypassed record taken by dispatch never occupies a slot
   assign push = done_ok && (!full || pop)
               && !(bypass_hit && out_ready);
   assign out_valid = !empty || bypass_hit;
   assign out_head = !empty   ? fifo_head
                   : bypass_hit ? fetch_head
                   : '0;
`else
   assign push      = done_ok && (!full || pop);
   assign out_valid = !empty;
   assign out_head  = empty ? '0 : fifo_head;
`endif

   // occupancy as it will be after this edge; one slot stays
   // reserved for whatever fetch is issued now
   always_comb begin
      count_next = count;
      if (redirect)
         count_next = '0;
      else if (push && !pop)
         count_next = count + ONE;
      else if (pop && !push)
         count_next = count - ONE;
   end

   assign room = (count_next < FULL_CNT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (redirect) begin
         if ((state == WAIT || state == DISCARD) && !fetch_done)
            state_next = DISCARD;
         else
            state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (room) state_next = WAIT;
            WAIT:
               if (fetch_done)
                  state_next = fault ? STALL
                             : room  ? WAIT
                             : IDLE;
            DISCARD: if (fetch_done) state_next = IDLE;
            STALL:   state_next = STALL;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      enable_next = 1'b0;
      if (!redirect) begin
         if (state == IDLE && room)
            enable_next = 1'b1;
         if (done_ok && !fault && room)
            enable_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_enable <= 1'b0;
         fetch_ptr    <= RESET_PC;
         stalled      <= 1'b0;
      end else begin
         fetch_enable <= enable_next;
         if (redirect) begin
            fetch_ptr <= {redirect_addr[63:2], 2'b00};
            stalled   <= 1'b0;
         end else if (done_ok) begin
            if (fault)
               stalled <= 1'b1;
            else
               fetch_ptr <= fetch_ptr + 64'd4;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect),
      .din     (fetch_head),
      .dout    (fifo_head),
      .count   (count),
      .empty   (empty),
      .full    (full)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a
// two-cycle fetch_unit model and a pop/enable monitor.
module tb_fetch_queue;
   import mmix_defs::*;

   localparam logic [63:0] RPC = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_enable;
   logic [63:0] fetch_ptr;
   logic        fetch_done = 1'b0;
   fetch        fetch_head = '0;
   logic        redirect;
   logic [63:0] redirect_addr;
   logic        out_valid;
   fetch        out_head;
   logic        out_ready;
   logic        stalled;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fetch_enable  (fetch_enable),
      .fetch_ptr     (fetch_ptr),
      .fetch_done    (fetch_done),
      .fetch_head    (fetch_head),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .out_valid     (out_valid),
      .out_head      (out_head),
      .out_ready     (out_ready),
      .stalled       (stalled)
   );

   function automatic fetch mk(input logic [63:0] a);
      fetch r;
      r.loc = a;
      r.interrupt = '0;
      if (a == 64'h100) begin
         r.inst = SWYM;
         r.interrupt[F_BIT] = 1'b1;
      end else begin
         r.inst = a[31:0] ^ 32'h1234_5678;
      end
      return r;
   endfunction

   // fetch_unit model: done is sampled two edges after enable
   int          m_cnt = 0;
   logic [63:0] m_ptr = '0;
   always @(negedge clk) begin
      fetch_done = 1'b0;
      fetch_head = '0;
      if (reset_n !== 1'b1) begin
         m_cnt = 0;
      end else begin
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               fetch_done = 1'b1;
               fetch_head = mk(m_ptr);
            end
         end
         if (fetch_enable === 1'b1) begin
            m_cnt = 1;
            m_ptr = fetch_ptr;
         end
      end
   end

   int          cyc = 0;
   int          n_enable = 0;
   logic [63:0] pops[$];
   logic [63:0] en_ptr[$];
   int          en_cyc[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      #3;
      if (fetch_enable === 1'b1) begin
         n_enable++;
         en_ptr.push_back(fetch_ptr);
         en_cyc.push_back(cyc);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1)
         pops.push_back(out_head.loc);
   end

   task automatic wait_en(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (fetch_enable === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      out_ready = 1'b0;
      redirect = 1'b0;
      redirect_addr = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (fetch_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_enable got %0b want 0", fetch_enable);
      end
      checks++;
      if (fetch_ptr !== RPC) begin
         errors++;
         $display("FAIL reset_ptr got %h want %h", fetch_ptr, RPC);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %0b want 0", out_valid);
      end
      checks++;
      if (out_head !== '0) begin
         errors++;
         $display("FAIL reset_head got %h want 0", out_head);
      end
      checks++;
      if (stalled !== 1'b0) begin
         errors++;
         $display("FAIL reset_stalled got %0b want 0", stalled);
      end
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (fetch_enable !== 1'b1 || fetch_ptr !== RPC) begin
         errors++;
         $display("FAIL first_fetch got en=%0b ptr=%h want en=1 ptr=%h",
                  fetch_enable, fetch_ptr, RPC);
      end
   endtask

   task automatic test_full();
      int base;
      fetch exp;
      base = n_enable;
      exp = mk(RPC);
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (n_enable - base !== 4) begin
         errors++;
         $display("FAIL full_pulses got %0d want 4", n_enable - base);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_valid got %0b want 1", out_valid);
      end
      checks++;
      if (out_head !== exp) begin
         errors++;
         $display("FAIL full_head got %h want %h", out_head, exp);
      end
      checks++;
      if (fetch_ptr !== RPC + 64'h10) begin
         errors++;
         $display("FAIL full_ptr got %h want %h", fetch_ptr, RPC + 64'h10);
      end
      checks++;
      if (fetch_enable !== 1'b0) begin
         errors++;
         $display("FAIL full_enable got %0b want 0", fetch_enable);
      end
   endtask

   task automatic test_stream();
      int bp;
      int be;
      bit gap_ok;
      out_ready = 1'b1;
      bp = pops.size();
      be = en_ptr.size();
      repeat (24) @(negedge clk);
      #3;
      checks++;
      if (en_ptr.size() <= be) begin
         errors++;
         $display("FAIL resume_ptr got none want %h", RPC + 64'h10);
      end else if (en_ptr[be] !== RPC + 64'h10) begin
         errors++;
         $display("FAIL resume_ptr got %h want %h", en_ptr[be], RPC + 64'h10);
      end
      checks++;
      if (pops.size() - bp < 10) begin
         errors++;
         $display("FAIL stream_count got %0d want >=10", pops.size() - bp);
      end else begin
         for (int i = 0; i < 10; i++) begin
            if (pops[bp + i] !== RPC + 64'(4 * i)) begin
               errors++;
               $display("FAIL stream_loc%0d got %h want %h",
                        i, pops[bp + i], RPC + 64'(4 * i));
            end
         end
      end
      gap_ok = 1'b1;
      for (int i = be + 1; i < en_cyc.size(); i++)
         if (en_cyc[i] - en_cyc[i - 1] != 2)
            gap_ok = 1'b0;
      checks++;
      if (gap_ok !== 1'b1 || en_cyc.size() - be < 8) begin
         errors++;
         $display("FAIL stream_gap got ok=%0b n=%0d want ok=1 n>=8",
                  gap_ok, en_cyc.size() - be);
      end
   endtask

   task automatic test_redirect_wait();
      bit ok;
      int bp;
      wait_en(ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL rdw_wait got timeout want enable");
      end
      redirect = 1'b1;
      redirect_addr = 64'h8000_0000_0000_1003;
      @(negedge clk);
      #1;
      redirect = 1'b0;
      bp = pops.size();
      checks++;
      if (fetch_ptr !== 64'h8000_0000_0000_1000) begin
         errors++;
         $display("FAIL rdw_ptr got %h want 8000000000001000", fetch_ptr);
      end
      checks++;
      if (out_valid !== 1'b0 || fetch_enable !== 1'b0) begin
         errors++;
         $display("FAIL rdw_flush got v=%0b en=%0b want 0 0",
                  out_valid, fetch_enable);
      end
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || fetch_enable !== 1'b0) begin
         errors++;
         $display("FAIL rdw_drop got v=%0b en=%0b want 0 0",
                  out_valid, fetch_enable);
      end
      @(negedge clk);
      #1;
      checks++;
      if (fetch_enable !== 1'b1 || fetch_ptr !== 64'h8000_0000_0000_1000) begin
         errors++;
         $display("FAIL rdw_restart got en=%0b ptr=%h want 1 8000000000001000",
                  fetch_enable, fetch_ptr);
      end
      repeat (10) @(negedge clk);
      #3;
      checks++;
      if (pops.size() - bp < 2) begin
         errors++;
         $display("FAIL rdw_pops got %0d want >=2", pops.size() - bp);
      end else if (pops[bp] !== 64'h8000_0000_0000_1000
                   || pops[bp + 1] !== 64'h8000_0000_0000_1004) begin
         errors++;
         $display("FAIL rdw_pops got %h %h want 8000000000001000 8000000000001004",
                  pops[bp], pops[bp + 1]);
      end
   endtask

   task automatic test_fault();
      bit ok;
      bit seen;
      int be;
      out_ready = 1'b0;
      wait_en(ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL flt_wait got timeout want enable");
      end
      redirect = 1'b1;
      redirect_addr = 64'h100;
      @(negedge clk);
      #1;
      redirect = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (stalled === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL flt_stalled got timeout want stalled=1");
      end
      checks++;
      if (out_valid !== 1'b1 || out_head.loc !== 64'h100) begin
         errors++;
         $display("FAIL flt_rec got v=%0b loc=%h want 1 100",
                  out_valid, out_head.loc);
      end
      checks++;
      if (out_head.interrupt[F_BIT] !== 1'b1 || out_head.inst !== SWYM) begin
         errors++;
         $display("FAIL flt_bits got f=%0b inst=%h want 1 %h",
                  out_head.interrupt[F_BIT], out_head.inst, SWYM);
      end
      checks++;
      if (fetch_ptr !== 64'h100) begin
         errors++;
         $display("FAIL flt_ptr got %h want 100", fetch_ptr);
      end
      be = n_enable;
      repeat (10) @(negedge clk);
      #3;
      checks++;
      if (n_enable - be !== 0 || stalled !== 1'b1) begin
         errors++;
         $display("FAIL flt_hold got pulses=%0d st=%0b want 0 1",
                  n_enable - be, stalled);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      #1;
      redirect = 1'b1;
      redirect_addr = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      #1;
      redirect = 1'b0;
      checks++;
      if (stalled !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL wrap_clear got st=%0b v=%0b want 0 0",
                  stalled, out_valid);
      end
      checks++;
      if (fetch_ptr !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_enable !== 1'b0) begin
         errors++;
         $display("FAIL wrap_ptr got %h en=%0b want fffffffffffffffc 0",
                  fetch_ptr, fetch_enable);
      end
      @(negedge clk);
      #1;
      checks++;
      if (fetch_enable !== 1'b1) begin
         errors++;
         $display("FAIL wrap_en got %0b want 1", fetch_enable);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (fetch_ptr !== 64'h0 || fetch_enable !== 1'b1) begin
         errors++;
         $display("FAIL wrap_next got %h en=%0b want 0 1",
                  fetch_ptr, fetch_enable);
      end
      checks++;
      if (out_valid !== 1'b1 || out_head.loc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_rec got v=%0b loc=%h want 1 fffffffffffffffc",
                  out_valid, out_head.loc);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int bp;
      out_ready = 1'b1;
      wait_en(ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL rst_wait got timeout want enable");
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (fetch_enable !== 1'b0 || fetch_ptr !== RPC || stalled !== 1'b0) begin
         errors++;
         $display("FAIL rst_regs got en=%0b ptr=%h st=%0b want 0 %h 0",
                  fetch_enable, fetch_ptr, stalled, RPC);
      end
      checks++;
      if (out_valid !== 1'b0 || out_head !== '0) begin
         errors++;
         $display("FAIL rst_out got v=%0b head=%h want 0 0",
                  out_valid, out_head);
      end
      repeat (2) @(negedge clk);
      #1;
      reset_n = 1'b1;
      bp = pops.size();
      @(negedge clk);
      #1;
      checks++;
      if (fetch_enable !== 1'b1 || fetch_ptr !== RPC) begin
         errors++;
         $display("FAIL rst_first got en=%0b ptr=%h want 1 %h",
                  fetch_enable, fetch_ptr, RPC);
      end
      repeat (8) @(negedge clk);
      #3;
      checks++;
      if (pops.size() - bp < 2) begin
         errors++;
         $display("FAIL rst_pops got %0d want >=2", pops.size() - bp);
      end else if (pops[bp] !== RPC || pops[bp + 1] !== RPC + 64'h4) begin
         errors++;
         $display("FAIL rst_pops got %h %h want %h %h",
                  pops[bp], pops[bp + 1], RPC, RPC + 64'h4);
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_stream();
      test_redirect_wait();
      test_fault();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
